// File: rtl/imem_boot_loader_pkg.sv
// Shared definitions for the instruction-memory boot loader.
`timescale 1ns/1ps
package imem_boot_loader_pkg;

  localparam int IMEM_DEPTH = 256;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_LOAD  = 3'd2,
    ST_RUN   = 3'd3,
    ST_ERROR = 3'd4
  } state_t;

endpackage

// File: rtl/imem_boot_loader.sv
// Boot loader: zero-fills instruction memory, streams a program into it, then releases the CPU.
`timescale 1ns/1ps
module imem_boot_loader
  import imem_boot_loader_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              load_req_i,
  input  logic              word_valid_i,
  input  logic [DATA_W-1:0] word_data_i,
  input  logic              word_last_i,
  output logic              word_ready_o,
  output logic              imem_we_o,
  output logic [ADDR_W-1:0] imem_addr_o,
  output logic [DATA_W-1:0] imem_data_o,
  output logic              cpu_rst_o,
  output logic              start_o,
  output logic [ADDR_W:0]   words_loaded_o,
  output logic              err_overflow_o,
  output logic              busy_o
);

  localparam logic [ADDR_W:0] DEPTH    = (ADDR_W+1)'(2**ADDR_W);
  localparam logic [ADDR_W:0] LAST_IDX = (ADDR_W+1)'(2**ADDR_W - 1);

  state_t state;
  logic   run_arm;
  logic   hs;
  logic   go_clear;

  assign word_ready_o = (state == ST_LOAD);
  assign busy_o       = (state == ST_CLEAR) || (state == ST_LOAD);
  assign hs           = word_valid_i & word_ready_o;
  // Requests are only honoured outside CLEAR/LOAD; a request during a handshake is dropped.
  assign go_clear     = load_req_i &&
                        ((state == ST_IDLE) || (state == ST_RUN) || (state == ST_ERROR));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state          <= ST_IDLE;
      run_arm        <= 1'b0;
      imem_we_o      <= 1'b0;
      imem_addr_o    <= '0;
      imem_data_o    <= '0;
      cpu_rst_o      <= 1'b1;
      start_o        <= 1'b0;
      words_loaded_o <= '0;
      err_overflow_o <= 1'b0;
    end else if (go_clear) begin
      // The first zero write is presented right after the request edge.
      state          <= ST_CLEAR;
      run_arm        <= 1'b0;
      imem_we_o      <= 1'b1;
      imem_addr_o    <= '0;
      imem_data_o    <= '0;
      cpu_rst_o      <= 1'b1;
      start_o        <= 1'b0;
      words_loaded_o <= '0;
      err_overflow_o <= 1'b0;
    end else begin
      imem_we_o <= 1'b0;
      case (state)
        ST_CLEAR: begin
          if (&imem_addr_o) begin
            state <= ST_LOAD;
          end else begin
            imem_we_o   <= 1'b1;
            imem_addr_o <= imem_addr_o + 1'b1;
          end
        end
        ST_LOAD: begin
          if (hs) begin
            imem_we_o   <= 1'b1;
            imem_addr_o <= words_loaded_o[ADDR_W-1:0];
            imem_data_o <= word_data_i;
            if (words_loaded_o != DEPTH) words_loaded_o <= words_loaded_o + 1'b1;
            if (word_last_i) begin
              state   <= ST_RUN;
              run_arm <= 1'b0;
            end else if (words_loaded_o == LAST_IDX) begin
              state          <= ST_ERROR;
              err_overflow_o <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          // One extra cycle so the final write commits before the CPU leaves reset.
          if (!run_arm) begin
            run_arm <= 1'b1;
          end else begin
            cpu_rst_o <= 1'b0;
            start_o   <= 1'b1;
          end
        end
        ST_IDLE, ST_ERROR: ;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Scoreboard bench for imem_boot_loader: expected writes queued by stimulus, checked by a monitor.
`timescale 1ns/1ps
module tb_imem_boot_loader;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 32;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_t;

  logic              clk_i = 1'b0;
  logic              rst_i = 1'b0;
  logic              load_req_i = 1'b0;
  logic              word_valid_i = 1'b0;
  logic [DATA_W-1:0] word_data_i = '0;
  logic              word_last_i = 1'b0;
  logic              word_ready_o;
  logic              imem_we_o;
  logic [ADDR_W-1:0] imem_addr_o;
  logic [DATA_W-1:0] imem_data_o;
  logic              cpu_rst_o;
  logic              start_o;
  logic [ADDR_W:0]   words_loaded_o;
  logic              err_overflow_o;
  logic              busy_o;

  imem_boot_loader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .load_req_i(load_req_i),
    .word_valid_i(word_valid_i), .word_data_i(word_data_i), .word_last_i(word_last_i),
    .word_ready_o(word_ready_o), .imem_we_o(imem_we_o), .imem_addr_o(imem_addr_o),
    .imem_data_o(imem_data_o), .cpu_rst_o(cpu_rst_o), .start_o(start_o),
    .words_loaded_o(words_loaded_o), .err_overflow_o(err_overflow_o), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  int          compared   = 0;
  int          mismatched = 0;
  wr_t         sbq[$];
  logic [31:0] mem [256];
  int          widx;

  // Monitor: every write the DUT presents must match the head of the queue.
  always @(negedge clk_i) begin
    if (imem_we_o === 1'b1) begin
      compared++;
      if (sbq.size() == 0) begin
        mismatched++;
        $display("FAIL sb_unexpected_write: got addr=%0d data=%h, required no write",
                 imem_addr_o, imem_data_o);
      end else begin
        wr_t e;
        e = sbq.pop_front();
        if (imem_addr_o !== e.addr || imem_data_o !== e.data) begin
          mismatched++;
          $display("FAIL sb_write: got addr=%0d data=%h, required addr=%0d data=%h",
                   imem_addr_o, imem_data_o, e.addr, e.data);
        end
      end
      mem[imem_addr_o] = imem_data_o;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h, required %h", nm, act, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_cpu_rst"}, 32'(cpu_rst_o), 32'd1);
    chk({tag, "_start"},   32'(start_o), 32'd0);
    chk({tag, "_ready"},   32'(word_ready_o), 32'd0);
    chk({tag, "_we"},      32'(imem_we_o), 32'd0);
    chk({tag, "_addr"},    32'(imem_addr_o), 32'd0);
    chk({tag, "_data"},    imem_data_o, 32'd0);
    chk({tag, "_count"},   32'(words_loaded_o), 32'd0);
    chk({tag, "_err"},     32'(err_overflow_o), 32'd0);
    chk({tag, "_busy"},    32'(busy_o), 32'd0);
  endtask

  // Called right after a negedge; pulses a request and waits for LOAD.
  task automatic start_load(input string tag);
    int n;
    for (int i = 0; i < 256; i++) sbq.push_back('{addr: ADDR_W'(i), data: '0});
    widx = 0;
    load_req_i = 1'b1;
    @(negedge clk_i);
    load_req_i = 1'b0;
    chk({tag, "_clr_busy"},    32'(busy_o), 32'd1);
    chk({tag, "_clr_cpu_rst"}, 32'(cpu_rst_o), 32'd1);
    chk({tag, "_clr_start"},   32'(start_o), 32'd0);
    chk({tag, "_clr_err"},     32'(err_overflow_o), 32'd0);
    n = 0;
    while (word_ready_o !== 1'b1 && n < 400) begin
      @(negedge clk_i);
      n++;
    end
    if (n >= 400) chk({tag, "_ready_timeout"}, 32'd0, 32'd1);
    chk({tag, "_clr_count"}, 32'(words_loaded_o), 32'd0);
  endtask

  task automatic send_word(input logic [31:0] d, input logic last, input logic req);
    int n;
    sbq.push_back('{addr: ADDR_W'(widx), data: d});
    widx++;
    word_valid_i = 1'b1;
    word_data_i  = d;
    word_last_i  = last;
    load_req_i   = req;
    n = 0;
    while (word_ready_o !== 1'b1 && n < 400) begin
      @(negedge clk_i);
      n++;
    end
    if (n >= 400) begin
      mismatched++;
      $display("FAIL hs_timeout: got ready=%b, required 1", word_ready_o);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $fatal(1);
    end
    @(posedge clk_i);
    @(negedge clk_i);
    word_valid_i = 1'b0;
    word_last_i  = 1'b0;
    load_req_i   = 1'b0;
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: got no finish, required finish");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched + 1);
    $fatal(1);
  end

  initial begin
    // 1: reset
    @(negedge clk_i);
    rst_i = 1'b1;
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;
    chk_reset_vals("rst");

    // 2: basic three-word program; release two edges after the last handshake
    start_load("basic");
    send_word(32'h00500093, 1'b0, 1'b0);
    send_word(32'h00100113, 1'b0, 1'b0);
    send_word(32'h002081B3, 1'b1, 1'b0);
    chk("basic_count",      32'(words_loaded_o), 32'd3);
    chk("basic_k0_cpu_rst", 32'(cpu_rst_o), 32'd1);
    chk("basic_k0_ready",   32'(word_ready_o), 32'd0);
    @(negedge clk_i);
    chk("basic_k1_cpu_rst", 32'(cpu_rst_o), 32'd1);
    chk("basic_k1_start",   32'(start_o), 32'd0);
    @(negedge clk_i);
    chk("basic_k2_cpu_rst", 32'(cpu_rst_o), 32'd0);
    chk("basic_k2_start",   32'(start_o), 32'd1);
    chk("basic_busy",       32'(busy_o), 32'd0);
    chk("basic_mem2",       mem[2], 32'h002081B3);

    // 3: 20 words with gaps; a load request during handshake 5 is dropped
    start_load("gaps");
    for (int i = 0; i < 20; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk_i);
      send_word(32'h1000_0000 + 32'(i), (i == 19), (i == 5));
    end
    chk("gaps_count", 32'(words_loaded_o), 32'd20);
    repeat (2) @(negedge clk_i);
    chk("gaps_start", 32'(start_o), 32'd1);

    // 6: reload from RUN replaces the 20-word program with a 2-word one
    load_req_i = 1'b1;
    for (int i = 0; i < 256; i++) sbq.push_back('{addr: ADDR_W'(i), data: '0});
    widx = 0;
    @(negedge clk_i);
    load_req_i = 1'b0;
    chk("reload_start",   32'(start_o), 32'd0);
    chk("reload_cpu_rst", 32'(cpu_rst_o), 32'd1);
    chk("reload_addr0",   32'(imem_addr_o), 32'd0);
    chk("reload_count",   32'(words_loaded_o), 32'd0);
    while (word_ready_o !== 1'b1 && widx < 400) begin
      @(negedge clk_i);
      widx++;
    end
    widx = 0;
    send_word(32'hAAAA0001, 1'b0, 1'b0);
    send_word(32'hAAAA0002, 1'b1, 1'b0);
    repeat (2) @(negedge clk_i);
    chk("reload_mem0", mem[0], 32'hAAAA0001);
    chk("reload_mem1", mem[1], 32'hAAAA0002);
    for (int i = 2; i < 20; i++) chk("reload_stale", mem[i], 32'd0);
    chk("reload_run_start", 32'(start_o), 32'd1);

    // 4: overflow after 256 words without last
    start_load("ovf");
    for (int i = 0; i < 256; i++) send_word(32'hE000_0000 | 32'(i), 1'b0, 1'b0);
    chk("ovf_err",     32'(err_overflow_o), 32'd1);
    chk("ovf_ready",   32'(word_ready_o), 32'd0);
    chk("ovf_cpu_rst", 32'(cpu_rst_o), 32'd1);
    chk("ovf_count",   32'(words_loaded_o), 32'd256);
    @(negedge clk_i);
    chk("ovf_hold_err", 32'(err_overflow_o), 32'd1);
    start_load("ovf_clr");
    send_word(32'h0000_0013, 1'b1, 1'b0);
    chk("ovf_clr_count", 32'(words_loaded_o), 32'd1);

    // 5: reset mid-LOAD, then a fresh 2-word load
    start_load("mid");
    for (int i = 0; i < 10; i++) send_word(32'h5000_0000 + 32'(i), 1'b0, 1'b0);
    chk("mid_count", 32'(words_loaded_o), 32'd10);
    rst_i = 1'b1;
    @(negedge clk_i);
    rst_i = 1'b0;
    chk_reset_vals("mid_rst");
    start_load("fresh");
    send_word(32'h6000_0000, 1'b0, 1'b0);
    send_word(32'h6000_0001, 1'b1, 1'b0);
    repeat (2) @(negedge clk_i);
    chk("fresh_count",   32'(words_loaded_o), 32'd2);
    chk("fresh_start",   32'(start_o), 32'd1);
    chk("fresh_cpu_rst", 32'(cpu_rst_o), 32'd0);

    repeat (3) @(negedge clk_i);
    chk("sb_drained", 32'(sbq.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
